// File: rtl/add_err_pkg.sv
// ----------------------------------------------------------------------------
// add_err_pkg
// Shared types and width helpers for the approximate-adder error monitor.
//   state_t : run-control FSM states
//   err_w   : width of |exact - approx| for a W-bit operand adder  (W+1)
//   sum_w   : width of the |error| accumulator                      (CNT_W+W+1)
//   sq_w    : width of the squared-error accumulator                (CNT_W+2W+2)
// ----------------------------------------------------------------------------
package add_err_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int err_w(input int w);
        return w + 1;
    endfunction

    function automatic int sum_w(input int cnt_w, input int w);
        return cnt_w + w + 1;
    endfunction

    function automatic int sq_w(input int cnt_w, input int w);
        return cnt_w + 2 * w + 2;
    endfunction

endpackage

// File: rtl/add_err_absdiff.sv
// ----------------------------------------------------------------------------
// add_err_absdiff
// Combinational absolute difference of two unsigned values.
//   x, y : WIDTH-bit unsigned inputs
//   d    : |x - y|, WIDTH bits (cannot overflow for unsigned operands)
// ----------------------------------------------------------------------------
module add_err_absdiff #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] d
);

    // Subtract the smaller from the larger so the result stays unsigned.
    assign d = (x >= y) ? (x - y) : (y - x);

endmodule

// File: rtl/add8u_err_monitor.sv
// ----------------------------------------------------------------------------
// add8u_err_monitor
// Streaming error-metric collector for an approximate W-bit adder. Each
// accepted sample (in_a, in_b, in_o) is compared against the exact sum and
// folded into sample count, sum of |error|, worst-case error and count of
// erroneous samples. A report generator divides the totals offline.
//
// Optional feature macro: ADD8U_ERR_MSE_EN
//   When defined, adds sq_err_sum (sum of err*err) for MSE. Latency is
//   unchanged because the square is registered alongside err in stage 1.
//
// Ports
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   start       : 1-cycle pulse; clears statistics and begins a run
//                 (honoured only in IDLE and DONE)
//   in_valid    : sample valid
//   in_ready    : high only in RUN; a sample is taken on in_valid & in_ready
//   in_a, in_b  : W-bit operands
//   in_o        : W+1-bit approximate sum under test
//   in_last     : marks the final sample of the run
//   busy        : high in RUN and DRAIN
//   stat_valid  : high in DONE; statistics stable until the next start
//   sample_cnt  : accepted samples, saturating
//   err_sum     : sum of |exact - in_o| (sized never to wrap)
//   wce         : largest |exact - in_o| seen
//   err_cnt     : samples with nonzero error, saturating
//   cnt_ovf     : sticky, sample_cnt hit its ceiling with more samples arriving
//   sq_err_sum  : sum of err*err (ADD8U_ERR_MSE_EN only)
// ----------------------------------------------------------------------------
module add8u_err_monitor
    import add_err_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 17
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [W-1:0]                in_a,
    input  logic [W-1:0]                in_b,
    input  logic [W:0]                  in_o,
    input  logic                        in_last,
    output logic                        busy,
    output logic                        stat_valid,
    output logic [CNT_W-1:0]            sample_cnt,
    output logic [sum_w(CNT_W, W)-1:0]  err_sum,
    output logic [W:0]                  wce,
    output logic [CNT_W-1:0]            err_cnt,
    output logic                        cnt_ovf
`ifdef ADD8U_ERR_MSE_EN
    ,
    output logic [sq_w(CNT_W, W)-1:0]   sq_err_sum
`endif
);

    localparam int EW   = err_w(W);
    localparam int SUMW = sum_w(CNT_W, W);
`ifdef ADD8U_ERR_MSE_EN
    localparam int SQW  = sq_w(CNT_W, W);
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state;

    logic          accept;
    logic          start_ok;
    logic [EW-1:0] exact;
    logic [EW-1:0] err;

    // Stage-1 registers
    logic          s1_valid;
    logic [EW-1:0] s1_err;
    logic          s1_nz;
`ifdef ADD8U_ERR_MSE_EN
    logic [2*EW-1:0] s1_sq;
`endif

    assign in_ready   = (state == RUN);
    assign busy       = (state == RUN) || (state == DRAIN);
    assign stat_valid = (state == DONE);

    assign accept   = in_valid && in_ready;
    assign start_ok = start && ((state == IDLE) || (state == DONE));

    assign exact = {1'b0, in_a} + {1'b0, in_b};

    add_err_absdiff #(.WIDTH(EW)) u_absdiff (
        .x (exact),
        .y (in_o),
        .d (err)
    );

    // ------------------------------------------------------------------
    // Run control
    // ------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking (<=) assignments so all
    // registers update from pre-edge values, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start_ok)           state <= RUN;
                RUN:     if (accept && in_last)  state <= DRAIN;
                // Only stage 1 can hold data on entry to DRAIN, and stage 2
                // absorbs it on this edge, so the pipe is empty afterwards.
                DRAIN:                           state <= DONE;
                DONE:    if (start_ok)           state <= RUN;
                default:                         state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: register the error of each accepted sample
    // ------------------------------------------------------------------
    // NOTE: datapath registers are reset too, so nothing stale can leak into
    // the accumulators after a mid-run reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_err   <= '0;
            s1_nz    <= 1'b0;
`ifdef ADD8U_ERR_MSE_EN
            s1_sq    <= '0;
`endif
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_err <= err;
                s1_nz  <= (err != '0);
`ifdef ADD8U_ERR_MSE_EN
                s1_sq  <= (2*EW)'(err) * (2*EW)'(err);
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: accumulators
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            err_sum    <= '0;
            wce        <= '0;
            err_cnt    <= '0;
            cnt_ovf    <= 1'b0;
`ifdef ADD8U_ERR_MSE_EN
            sq_err_sum <= '0;
`endif
        end else if (start_ok) begin
            sample_cnt <= '0;
            err_sum    <= '0;
            wce        <= '0;
            err_cnt    <= '0;
            cnt_ovf    <= 1'b0;
`ifdef ADD8U_ERR_MSE_EN
            sq_err_sum <= '0;
`endif
        end else if (s1_valid) begin
            if (sample_cnt == CNT_MAX) begin
                cnt_ovf <= 1'b1;
            end else begin
                sample_cnt <= sample_cnt + 1'b1;
            end
            if (s1_nz && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + 1'b1;
            end
            err_sum <= err_sum + SUMW'(s1_err);
            // Strict compare: ties keep the earlier maximum.
            if (s1_err > wce) begin
                wce <= s1_err;
            end
`ifdef ADD8U_ERR_MSE_EN
            sq_err_sum <= sq_err_sum + SQW'(s1_sq);
`endif
        end
    end

endmodule

// File: tb/tb_add8u_err_monitor.sv
// ----------------------------------------------------------------------------
// tb_add8u_err_monitor
// Directed self-checking bench. Instance u_a uses the default widths; u_b uses
// CNT_W=4 to reach counter saturation quickly. Both share the sample bus and
// reset but have separate start pulses, so whichever is not being exercised
// sits in IDLE/DONE and must ignore the traffic.
// ----------------------------------------------------------------------------
module tb_add8u_err_monitor;

    localparam int W   = 8;
    localparam int CA  = 17;
    localparam int CB  = 4;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b;
    logic in_valid, in_last;
    logic [W-1:0] in_a, in_b;
    logic [W:0]   in_o;

    logic              in_ready_a, busy_a, stat_valid_a, cnt_ovf_a;
    logic [CA-1:0]     sample_cnt_a, err_cnt_a;
    logic [CA+W:0]     err_sum_a;
    logic [W:0]        wce_a;
    logic              in_ready_b, busy_b, stat_valid_b, cnt_ovf_b;
    logic [CB-1:0]     sample_cnt_b, err_cnt_b;
    logic [CB+W:0]     err_sum_b;
    logic [W:0]        wce_b;
`ifdef ADD8U_ERR_MSE_EN
    logic [CA+2*W+1:0] sq_err_sum_a;
    logic [CB+2*W+1:0] sq_err_sum_b;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    add8u_err_monitor #(.W(W), .CNT_W(CA)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid),
        .in_ready(in_ready_a), .in_a(in_a), .in_b(in_b), .in_o(in_o),
        .in_last(in_last), .busy(busy_a), .stat_valid(stat_valid_a),
        .sample_cnt(sample_cnt_a), .err_sum(err_sum_a), .wce(wce_a),
        .err_cnt(err_cnt_a), .cnt_ovf(cnt_ovf_a)
`ifdef ADD8U_ERR_MSE_EN
        , .sq_err_sum(sq_err_sum_a)
`endif
    );

    add8u_err_monitor #(.W(W), .CNT_W(CB)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid),
        .in_ready(in_ready_b), .in_a(in_a), .in_b(in_b), .in_o(in_o),
        .in_last(in_last), .busy(busy_b), .stat_valid(stat_valid_b),
        .sample_cnt(sample_cnt_b), .err_sum(err_sum_b), .wce(wce_b),
        .err_cnt(err_cnt_b), .cnt_ovf(cnt_ovf_b)
`ifdef ADD8U_ERR_MSE_EN
        , .sq_err_sum(sq_err_sum_b)
`endif
    );

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W:0] o, input logic last);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_o     = o;
        in_last  = last;
    endtask

    task automatic idle_bus();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_start(input bit sel_b);
        @(negedge clk);
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Bounded wait for stat_valid; a timeout is a failed comparison.
    task automatic wait_done(input bit sel_b, input string tag);
        int k = 0;
        while (!(sel_b ? stat_valid_b : stat_valid_a) && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (!(sel_b ? stat_valid_b : stat_valid_a)) begin
            n_err++;
            $display("FAIL %s_timeout: stat_valid=0 after %0d cycles, required 1", tag, k);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0; in_o = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({in_ready_a, busy_a, stat_valid_a, cnt_ovf_a} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl_a: got %b required 0000", {in_ready_a, busy_a, stat_valid_a, cnt_ovf_a});
        end
        n_vec++;
        if ({sample_cnt_a, err_sum_a, wce_a, err_cnt_a} !== '0) begin
            n_err++;
            $display("FAIL reset_stats_a: cnt=%0d sum=%0d wce=%0d ecnt=%0d required all 0",
                     sample_cnt_a, err_sum_a, wce_a, err_cnt_a);
        end
        n_vec++;
        if ({in_ready_b, busy_b, stat_valid_b, cnt_ovf_b, sample_cnt_b, err_sum_b} !== '0) begin
            n_err++;
            $display("FAIL reset_b: ctrl=%b cnt=%0d sum=%0d required 0",
                     {in_ready_b, busy_b, stat_valid_b, cnt_ovf_b}, sample_cnt_b, err_sum_b);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_exhaustive_exact();
        pulse_start(1'b0);
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                send(W'(a), W'(b), (W+1)'(a + b), (a == 255) && (b == 255));
            end
        end
        idle_bus();
        wait_done(1'b0, "exh");
        n_vec++;
        if (sample_cnt_a !== 17'd65536) begin
            n_err++;
            $display("FAIL exh_sample_cnt: got %0d required 65536", sample_cnt_a);
        end
        n_vec++;
        if ({err_sum_a, wce_a, err_cnt_a, cnt_ovf_a} !== '0) begin
            n_err++;
            $display("FAIL exh_errors: sum=%0d wce=%0d ecnt=%0d ovf=%0d required all 0",
                     err_sum_a, wce_a, err_cnt_a, cnt_ovf_a);
        end
`ifdef ADD8U_ERR_MSE_EN
        n_vec++;
        if (sq_err_sum_a !== '0) begin
            n_err++;
            $display("FAIL exh_sq: got %0d required 0", sq_err_sum_a);
        end
`endif
    endtask

    // Consecutive samples with no bubbles: errors 2, 14, 0.
    task automatic test_back_to_back();
        pulse_start(1'b0);
        send(8'd3,   8'd5,   9'd6,     1'b0);
        send(8'd255, 8'd255, 9'h1F0,   1'b0);
        send(8'd0,   8'd0,   9'd0,     1'b1);
        idle_bus();
        wait_done(1'b0, "b2b");
        n_vec++;
        if (err_sum_a !== 26'd16) begin
            n_err++;
            $display("FAIL b2b_err_sum: got %0d required 16", err_sum_a);
        end
        n_vec++;
        if (wce_a !== 9'd14) begin
            n_err++;
            $display("FAIL b2b_wce: got %0d required 14", wce_a);
        end
        n_vec++;
        if (err_cnt_a !== 17'd2 || sample_cnt_a !== 17'd3) begin
            n_err++;
            $display("FAIL b2b_counts: err_cnt=%0d sample_cnt=%0d required 2 and 3", err_cnt_a, sample_cnt_a);
        end
        n_vec++;
        if (busy_a !== 1'b0 || in_ready_a !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_done_ctrl: busy=%b in_ready=%b required 0 0", busy_a, in_ready_a);
        end
`ifdef ADD8U_ERR_MSE_EN
        n_vec++;
        if (sq_err_sum_a !== 35'd200) begin
            n_err++;
            $display("FAIL b2b_sq: got %0d required 200", sq_err_sum_a);
        end
`endif
    endtask

    // Single sample: accept on edge e0, DRAIN after e0, DONE after e1.
    task automatic test_latency();
        pulse_start(1'b0);
        send(8'd1, 8'd1, 9'd3, 1'b1);
        idle_bus();  // now just past e0
        n_vec++;
        if ({stat_valid_a, in_ready_a, busy_a} !== 3'b001) begin
            n_err++;
            $display("FAIL lat_drain: sv,rdy,busy=%b required 001", {stat_valid_a, in_ready_a, busy_a});
        end
        @(negedge clk);  // just past e1
        n_vec++;
        if ({stat_valid_a, in_ready_a, busy_a} !== 3'b100) begin
            n_err++;
            $display("FAIL lat_done: sv,rdy,busy=%b required 100", {stat_valid_a, in_ready_a, busy_a});
        end
        n_vec++;
        if (err_sum_a !== 26'd1 || wce_a !== 9'd1) begin
            n_err++;
            $display("FAIL lat_err_sum: sum=%0d wce=%0d required 1 1", err_sum_a, wce_a);
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (stat_valid_a !== 1'b1 || err_sum_a !== 26'd1) begin
            n_err++;
            $display("FAIL lat_hold: sv=%b sum=%0d required 1 1", stat_valid_a, err_sum_a);
        end
    endtask

    // CNT_W=4: 20 samples of error 1 saturate both counters at 15.
    task automatic test_saturation();
        pulse_start(1'b1);
        for (int i = 0; i < 20; i++) send(8'd0, 8'd0, 9'd1, i == 19);
        idle_bus();
        wait_done(1'b1, "sat");
        n_vec++;
        if (sample_cnt_b !== 4'd15 || err_cnt_b !== 4'd15) begin
            n_err++;
            $display("FAIL sat_counts: sample_cnt=%0d err_cnt=%0d required 15 15", sample_cnt_b, err_cnt_b);
        end
        n_vec++;
        if (cnt_ovf_b !== 1'b1) begin
            n_err++;
            $display("FAIL sat_ovf: got %b required 1", cnt_ovf_b);
        end
        n_vec++;
        if (err_sum_b !== 13'd20 || wce_b !== 9'd1) begin
            n_err++;
            $display("FAIL sat_err_sum: sum=%0d wce=%0d required 20 1", err_sum_b, wce_b);
        end
        // u_a was in DONE throughout and must still hold the previous run.
        n_vec++;
        if (sample_cnt_a !== 17'd1 || err_sum_a !== 26'd1) begin
            n_err++;
            $display("FAIL sat_other_idle: a.cnt=%0d a.sum=%0d required 1 1", sample_cnt_a, err_sum_a);
        end
    endtask

    task automatic test_reset_mid_run();
        pulse_start(1'b0);
        for (int i = 0; i < 5; i++) send(8'd0, 8'd0, 9'd7, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({busy_a, in_ready_a, sample_cnt_a, err_sum_a} !== '0) begin
            n_err++;
            $display("FAIL rmid_async: busy=%b rdy=%b cnt=%0d sum=%0d required all 0",
                     busy_a, in_ready_a, sample_cnt_a, err_sum_a);
        end
        @(negedge clk);
        rst = 1'b0;
        pulse_start(1'b0);
        send(8'd2, 8'd2, 9'd4, 1'b1);
        idle_bus();
        wait_done(1'b0, "rmid");
        n_vec++;
        if (sample_cnt_a !== 17'd1 || err_sum_a !== 26'd0) begin
            n_err++;
            $display("FAIL rmid_stats: cnt=%0d sum=%0d required 1 0", sample_cnt_a, err_sum_a);
        end
        n_vec++;
        if (wce_a !== 9'd0 || err_cnt_a !== 17'd0 || cnt_ovf_a !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_err: wce=%0d ecnt=%0d ovf=%b required 0 0 0", wce_a, err_cnt_a, cnt_ovf_a);
        end
    endtask

    task automatic test_ignored();
        // Fresh reset leaves u_a in IDLE; traffic there must be dropped.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) send(8'd0, 8'd0, 9'd9, 1'b0);
        n_vec++;
        if (in_ready_a !== 1'b0 || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL ign_idle_ctrl: rdy=%b busy=%b required 0 0", in_ready_a, busy_a);
        end
        idle_bus();
        @(negedge clk);
        n_vec++;
        if (sample_cnt_a !== 17'd0 || err_sum_a !== 26'd0) begin
            n_err++;
            $display("FAIL ign_idle_stats: cnt=%0d sum=%0d required 0 0", sample_cnt_a, err_sum_a);
        end
        pulse_start(1'b0);
        send(8'd0, 8'd0, 9'd1, 1'b0);
        send(8'd0, 8'd0, 9'd1, 1'b0);
        idle_bus();
        pulse_start(1'b0);  // in RUN: must not clear
        send(8'd0, 8'd0, 9'd3, 1'b1);
        idle_bus();
        wait_done(1'b0, "ign");
        n_vec++;
        if (sample_cnt_a !== 17'd3 || err_sum_a !== 26'd5) begin
            n_err++;
            $display("FAIL ign_run_start: cnt=%0d sum=%0d required 3 5", sample_cnt_a, err_sum_a);
        end
        n_vec++;
        if (err_cnt_a !== 17'd3 || wce_a !== 9'd3) begin
            n_err++;
            $display("FAIL ign_run_err: ecnt=%0d wce=%0d required 3 3", err_cnt_a, wce_a);
        end
    endtask

    initial begin
        test_reset();
        test_exhaustive_exact();
        test_back_to_back();
        test_latency();
        test_saturation();
        test_reset_mid_run();
        test_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
